// File: rtl/load_store_unit.sv
// Byte-serial load/store engine: moves 1..4 bytes between the core and a
// single-byte data memory, one byte per cycle, wrapping at the top of memory.
module load_store_unit #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AW-1:0]     req_addr,
  input  logic [1:0]        req_len,
  input  logic [4*DW-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [4*DW-1:0]   resp_rdata,
  output logic              resp_wrap,
  output logic [AW-1:0]     MemAdr,
  output logic              ReadEn,
  output logic              WriteEn,
  output logic [DW-1:0]     DatIn,
  input  logic [DW-1:0]     DatOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [AW-1:0]     base_q, base_d;
  logic [1:0]        len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [4*DW-1:0]   wdata_q, wdata_d;
  logic [4*DW-1:0]   rdata_q, rdata_d;
  logic              wrap_q, wrap_d;

  logic [AW:0]       addr_sum_s;
  logic [AW-1:0]     mem_adr_s;
  logic              read_en_s;
  logic              write_en_s;
  logic [DW-1:0]     dat_in_s;

  // The extra top bit of the sum flags that this byte's address wrapped past 2**AW-1.
  assign addr_sum_s = {1'b0, base_q} + {{(AW-1){1'b0}}, idx_q};

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      base_q  <= '0;
      len_q   <= 2'd0;
      idx_q   <= 2'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state, request capture and memory-port decode.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wrap_d     = wrap_q;
    mem_adr_s  = '0;
    read_en_s  = 1'b0;
    write_en_s = 1'b0;
    dat_in_s   = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          base_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          rdata_d = '0;
          wrap_d  = 1'b0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        mem_adr_s = addr_sum_s[AW-1:0];
        if (addr_sum_s[AW]) begin
          wrap_d = 1'b1;
        end else begin
          wrap_d = wrap_q;
        end
        if (write_q) begin
          write_en_s = 1'b1;
          dat_in_s   = wdata_q[idx_q*DW +: DW];
        end else begin
          read_en_s  = 1'b1;
          rdata_d[idx_q*DW +: DW] = DatOut;
        end
        if (idx_q == len_q) begin
          state_d = RESP;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_wrap  = wrap_q;
  assign MemAdr     = mem_adr_s;
  assign ReadEn     = read_en_s;
  // Gate the write strobe with reset so an abort never writes memory.
  assign WriteEn    = write_en_s & rst_n;
  assign DatIn      = dat_in_s;

endmodule
